// File: rtl/wb_slave_router.sv
// wb_slave_router
// Registered Wishbone router between the management-SoC slave port and two
// user slaves: UART (adr[31:24] == UART_BASE) and user memory (MEM_BASE).
// One transaction is in flight at a time. Every access terminates upstream:
// - with the slave's data when the slave acks,
// - with ERR_DATA after TIMEOUT strobe cycles without an ack,
// - with ERR_DATA at once for an unmapped address.
// Optional feature macro: WB_ROUTER_STATS_EN. When it is defined, CSR_BASE
// decodes to completion counters and a write-1-to-clear error register.
// When it is undefined, CSR_BASE is an unmapped address.
module wb_slave_router #(
  parameter logic [7:0]  UART_BASE = 8'h30,
  parameter logic [7:0]  MEM_BASE  = 8'h38,
  parameter logic [7:0]  CSR_BASE  = 8'h3F,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hBAD0_BAD0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        uart_cyc_o,
  output logic        uart_stb_o,
  input  logic        uart_ack_i,
  input  logic [31:0] uart_dat_i,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_dat_i,
  output logic        err_irq_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RESP = 2'd2
  } state_e;

  // The last strobe cycle that still waits for an ack. The counter reads 0
  // in the first strobe cycle, so the target is strobed for TIMEOUT cycles.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

`ifdef WB_ROUTER_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic        tgt_mem_q, tgt_mem_d;     // selected slave while in FWD: 0 = UART, 1 = memory
  logic        uart_req_q, uart_req_d;   // drives uart_cyc_o / uart_stb_o
  logic        mem_req_q, mem_req_d;     // drives mem_cyc_o / mem_stb_o
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        ack_q, ack_d;
  logic [31:0] rdat_q, rdat_d;
  logic        to_flag_q, to_flag_d;
  logic        unmap_flag_q, unmap_flag_d;
`ifdef WB_ROUTER_STATS_EN
  logic [31:0] uart_cnt_q, uart_cnt_d;
  logic [31:0] mem_cnt_q, mem_cnt_d;
`endif

  logic        accept;
  logic        uart_hit, mem_hit, csr_hit;
  logic        csr_clr;
  logic        tgt_ack;
  logic [31:0] tgt_dat;
  logic [31:0] csr_rdata;

  assign accept   = wbs_stb_i & wbs_cyc_i;
  assign uart_hit = (wbs_adr_i[31:24] == UART_BASE);
  assign mem_hit  = (wbs_adr_i[31:24] == MEM_BASE);
  assign csr_hit  = STATS_EN && (wbs_adr_i[31:24] == CSR_BASE);
  // Error-flag clear: a CSR write to offset 0x8 with byte lane 0 enabled.
  assign csr_clr  = wbs_we_i & wbs_sel_i[0] & (wbs_adr_i[23:0] == 24'h8);

  // Only the selected slave's ack and data are looked at; the other slave is ignored.
  assign tgt_ack = tgt_mem_q ? mem_ack_i : uart_ack_i;
  assign tgt_dat = tgt_mem_q ? mem_dat_i : uart_dat_i;

  // CSR read mux, addressed by the offset inside the CSR window.
  always_comb begin
    csr_rdata = '0;
`ifdef WB_ROUTER_STATS_EN
    case (wbs_adr_i[23:0])
      24'h0:   csr_rdata = uart_cnt_q;
      24'h4:   csr_rdata = mem_cnt_q;
      24'h8:   csr_rdata = {30'd0, unmap_flag_q, to_flag_q};
      default: csr_rdata = '0;
    endcase
`endif
  end

  // Next-state and output computation for the IDLE -> FWD -> RESP transaction flow.
  // NOTE: every signal gets a default before the case statement. This means no
  // path through the block leaves a signal unassigned, so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    tgt_mem_d    = tgt_mem_q;
    uart_req_d   = uart_req_q;
    mem_req_d    = mem_req_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    sel_d        = sel_q;
    adr_d        = adr_q;
    wdat_d       = wdat_q;
    ack_d        = 1'b0;
    rdat_d       = '0;
    to_flag_d    = to_flag_q;
    unmap_flag_d = unmap_flag_q;
`ifdef WB_ROUTER_STATS_EN
    uart_cnt_d   = uart_cnt_q;
    mem_cnt_d    = mem_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d   = wbs_we_i;
          sel_d  = wbs_sel_i;
          adr_d  = wbs_adr_i;
          wdat_d = wbs_dat_i;
          cnt_d  = '0;
          if (uart_hit) begin
            tgt_mem_d  = 1'b0;
            uart_req_d = 1'b1;
            state_d    = FWD;
          end else if (mem_hit) begin
            tgt_mem_d = 1'b1;
            mem_req_d = 1'b1;
            state_d   = FWD;
          end else if (csr_hit) begin
            ack_d   = 1'b1;
            rdat_d  = csr_rdata;
            state_d = RESP;
            if (csr_clr) begin
              to_flag_d    = to_flag_q & ~wbs_dat_i[0];
              unmap_flag_d = unmap_flag_q & ~wbs_dat_i[1];
            end
          end else begin
            ack_d        = 1'b1;
            rdat_d       = ERR_DATA;
            unmap_flag_d = 1'b1;
            state_d      = RESP;
          end
        end
      end

      FWD: begin
        cnt_d = cnt_q + 8'd1;
        if (!wbs_cyc_i) begin
          // The master abandoned the cycle. Release the slave without an upstream ack.
          uart_req_d = 1'b0;
          mem_req_d  = 1'b0;
          state_d    = IDLE;
        end else if (tgt_ack) begin
          // An ack in the final wait cycle still wins over the timeout.
          uart_req_d = 1'b0;
          mem_req_d  = 1'b0;
          ack_d      = 1'b1;
          rdat_d     = tgt_dat;
          state_d    = RESP;
`ifdef WB_ROUTER_STATS_EN
          if (tgt_mem_q) mem_cnt_d  = mem_cnt_q + 32'd1;
          else           uart_cnt_d = uart_cnt_q + 32'd1;
`endif
        end else if (cnt_q == TO_LAST) begin
          uart_req_d = 1'b0;
          mem_req_d  = 1'b0;
          ack_d      = 1'b1;
          rdat_d     = ERR_DATA;
          to_flag_d  = 1'b1;
          state_d    = RESP;
        end
      end

      RESP: begin
        // The ack and data registered on entry are visible during this cycle.
        // The defaults clear both for the next cycle.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset.
  // NOTE: sequential state is updated only with non-blocking assignments.
  // This means every flop samples the values from before the edge, whatever
  // order the statements are written in.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      tgt_mem_q    <= 1'b0;
      uart_req_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      adr_q        <= '0;
      wdat_q       <= '0;
      ack_q        <= 1'b0;
      rdat_q       <= '0;
      to_flag_q    <= 1'b0;
      unmap_flag_q <= 1'b0;
`ifdef WB_ROUTER_STATS_EN
      uart_cnt_q   <= '0;
      mem_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tgt_mem_q    <= tgt_mem_d;
      uart_req_q   <= uart_req_d;
      mem_req_q    <= mem_req_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      adr_q        <= adr_d;
      wdat_q       <= wdat_d;
      ack_q        <= ack_d;
      rdat_q       <= rdat_d;
      to_flag_q    <= to_flag_d;
      unmap_flag_q <= unmap_flag_d;
`ifdef WB_ROUTER_STATS_EN
      uart_cnt_q   <= uart_cnt_d;
      mem_cnt_q    <= mem_cnt_d;
`endif
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = rdat_q;
  assign s_we_o     = we_q;
  assign s_sel_o    = sel_q;
  assign s_adr_o    = adr_q;
  assign s_dat_o    = wdat_q;
  assign uart_cyc_o = uart_req_q;
  assign uart_stb_o = uart_req_q;
  assign mem_cyc_o  = mem_req_q;
  assign mem_stb_o  = mem_req_q;
  assign err_irq_o  = to_flag_q | unmap_flag_q;

endmodule

// File: tb/tb_wb_slave_router.sv
// Self-checking bench for wb_slave_router.
// The expected results come from a transaction-level model of the routing rules:
// - the decode class of the address,
// - the wait length the slave model chooses,
// - the timeout limit,
// - the sticky flags and completion counters.
// The bench does not model any cycle-level state.
module tb_wb_slave_router;

  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        uart_cyc_o, uart_stb_o, uart_ack_i;
  logic [31:0] uart_dat_i;
  logic        mem_cyc_o, mem_stb_o, mem_ack_i;
  logic [31:0] mem_dat_i;
  logic        err_irq_o;

  always #5 clk = ~clk;

  wb_slave_router #(.TIMEOUT(TO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .s_we_o    (s_we_o),
    .s_sel_o   (s_sel_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .uart_cyc_o(uart_cyc_o),
    .uart_stb_o(uart_stb_o),
    .uart_ack_i(uart_ack_i),
    .uart_dat_i(uart_dat_i),
    .mem_cyc_o (mem_cyc_o),
    .mem_stb_o (mem_stb_o),
    .mem_ack_i (mem_ack_i),
    .mem_dat_i (mem_dat_i),
    .err_irq_o (err_irq_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_to, m_unmap;
  int unsigned m_uart_cnt, m_mem_cnt;

  // Address class: 0 = UART, 1 = memory, 2 = router CSR, 3 = unmapped
  function automatic int kind_of(input logic [31:0] adr);
    if (adr[31:24] == 8'h30) return 0;
    if (adr[31:24] == 8'h38) return 1;
`ifdef WB_ROUTER_STATS_EN
    if (adr[31:24] == 8'h3F) return 2;
`endif
    return 3;
  endfunction

  function automatic logic [31:0] csr_model(input logic [23:0] off);
    case (off)
      24'h0:   return m_uart_cnt;
      24'h4:   return m_mem_cnt;
      24'h8:   return {30'd0, m_unmap, m_to};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},  wbs_ack_o, 0);
    check({tag, "_dato"}, wbs_dat_o, 0);
    check({tag, "_sadr"}, s_adr_o, 0);
    check({tag, "_sdat"}, s_dat_o, 0);
    check({tag, "_ctl"},  {s_we_o, s_sel_o, uart_cyc_o, uart_stb_o, mem_cyc_o, mem_stb_o}, 0);
    check({tag, "_irq"},  err_irq_o, 0);
  endtask

  // Runs one complete transaction. The slave acks in strobe cycle w
  // (w = 1 is zero-wait), and w > TO means the slave never acks.
  // Inputs change and outputs are sampled on the falling edge.
  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                         input logic [3:0] sel, input int w, input logic [31:0] sdat);
    int          kind, exp_ack_k, exp_u, exp_m, ustb, mstb, stb_idx, ack_k;
    logic [31:0] exp_dat, got_dat;
    kind      = kind_of(adr);
    exp_u     = 0;
    exp_m     = 0;
    exp_ack_k = 1;
    exp_dat   = ERR;
    if (kind == 0 || kind == 1) begin
      if (kind == 0) exp_u = (w > TO) ? TO : w;
      else           exp_m = (w > TO) ? TO : w;
      exp_ack_k = ((w > TO) ? TO : w) + 1;
      exp_dat   = (w <= TO) ? sdat : ERR;
    end else if (kind == 2) begin
      exp_dat = csr_model(adr[23:0]);
    end

    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = wdat;
    ustb = 0; mstb = 0; stb_idx = 0; ack_k = 0; got_dat = '0;
    for (int k = 1; k <= TO + 4 && ack_k == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("s_adr", s_adr_o, adr);
        check("s_dat", s_dat_o, wdat);
        check("s_we_sel", {s_we_o, s_sel_o}, {we, sel});
      end
      if (uart_stb_o) ustb++;
      if (mem_stb_o)  mstb++;
      uart_ack_i = 1'b0; mem_ack_i = 1'b0;
      uart_dat_i = $urandom; mem_dat_i = $urandom;
      if ((kind == 0 && uart_stb_o) || (kind == 1 && mem_stb_o)) begin
        stb_idx++;
        // The non-selected slave acks at random and must be ignored.
        if (kind == 0) begin
          mem_ack_i = 1'($urandom_range(0, 1));
          if (stb_idx == w) begin uart_ack_i = 1'b1; uart_dat_i = sdat; end
        end else begin
          uart_ack_i = 1'($urandom_range(0, 1));
          if (stb_idx == w) begin mem_ack_i = 1'b1; mem_dat_i = sdat; end
        end
      end
      if (wbs_ack_o) begin
        ack_k   = k;
        got_dat = wbs_dat_o;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    uart_ack_i = 1'b0; mem_ack_i = 1'b0;
    check("ack_latency", ack_k, exp_ack_k);
    check("ack_data", got_dat, exp_dat);
    check("uart_stb_cycles", ustb, exp_u);
    check("mem_stb_cycles", mstb, exp_m);

    // Update the model.
    if (kind == 3) m_unmap = 1'b1;
    if ((kind == 0 || kind == 1) && w > TO) m_to = 1'b1;
    if (kind == 0 && w <= TO) m_uart_cnt++;
    if (kind == 1 && w <= TO) m_mem_cnt++;
    if (kind == 2 && we && sel[0] && adr[23:0] == 24'h8) begin
      if (wdat[0]) m_to = 1'b0;
      if (wdat[1]) m_unmap = 1'b0;
    end

    @(negedge clk);
    check("ack_single", {wbs_ack_o, uart_stb_o, mem_stb_o}, 0);
    check("dat_idle", wbs_dat_o, 0);
    check("err_irq", err_irq_o, {31'd0, m_to | m_unmap});
  endtask

  // The master drops cyc after `hold` strobe cycles (hold < TO, no slave ack).
  task automatic abort_txn(input logic [31:0] adr, input int hold);
    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = adr;  wbs_dat_i = $urandom;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      check("abort_no_ack", wbs_ack_o, 0);
    end
    check("abort_stb_hi", (kind_of(adr) == 0) ? uart_stb_o : mem_stb_o, 1);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(negedge clk);
    check("abort_stb_drop", {uart_stb_o, mem_stb_o, wbs_ack_o}, 0);
    @(negedge clk);
    check("abort_no_ack_late", wbs_ack_o, 0);
    check("abort_irq", err_irq_o, {31'd0, m_to | m_unmap});
  endtask

  task automatic reset_mid_fwd(input logic [31:0] adr);
    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'h3; wbs_adr_i = adr;  wbs_dat_i = 32'hCAFE_F00D;
    @(negedge clk);
    @(negedge clk);
    check("rst_stb_hi", (kind_of(adr) == 0) ? uart_stb_o : mem_stb_o, 1);
    rst = 1'b1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    m_to = 1'b0; m_unmap = 1'b0; m_uart_cnt = 0; m_mem_cnt = 0;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [7:0] hi;
    case ($urandom_range(0, 3))
      0: return {8'h30, 24'($urandom)};
      1: return {8'h38, 24'($urandom)};
      2: return {8'h3F, 20'd0, 2'($urandom_range(0, 3)), 2'b00};
      default: begin
        hi = 8'($urandom);
        while (hi == 8'h30 || hi == 8'h38) hi = 8'($urandom);
        return {hi, 24'($urandom)};
      end
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    int          w;
    rst = 1'b1;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    uart_ack_i = 0; uart_dat_i = 0; mem_ack_i = 0; mem_dat_i = 0;
    m_to = 0; m_unmap = 0; m_uart_cnt = 0; m_mem_cnt = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Directed cases
    run_txn(32'h3000_0004, 1'b0, 32'h0,         4'hF, 3,      32'h0000_00A5);
    run_txn(32'h3800_0010, 1'b1, 32'h1234_5678, 4'hF, 1,      32'h5555_AAAA);
    run_txn(32'h3000_0008, 1'b0, 32'h0,         4'h1, TO,     32'h0BAD_F00D); // ack in last allowed cycle
    run_txn(32'h3800_0000, 1'b0, 32'h0,         4'hF, 1000,   32'h0);         // never acks -> timeout
    run_txn(32'h2000_0000, 1'b0, 32'h0,         4'hF, 1,      32'h0);         // unmapped
    abort_txn(32'h3000_0100, 4);
    reset_mid_fwd(32'h3800_0020);

`ifdef WB_ROUTER_STATS_EN
    run_txn(32'h3000_0000, 1'b0, 32'h0, 4'hF, 2, 32'h11);
    run_txn(32'h3000_0004, 1'b1, 32'h7, 4'hF, 1, 32'h22);
    run_txn(32'h3800_0004, 1'b0, 32'h0, 4'hF, 4, 32'h33);
    run_txn(32'h3F00_0000, 1'b0, 32'h0, 4'hF, 1, 32'h0);
    run_txn(32'h3F00_0004, 1'b0, 32'h0, 4'hF, 1, 32'h0);
    run_txn(32'h2000_0000, 1'b0, 32'h0, 4'hF, 1, 32'h0);
    run_txn(32'h3F00_0008, 1'b1, 32'h3, 4'h1, 1, 32'h0);
    check("stats_irq_cleared", err_irq_o, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      a = rand_addr();
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(1, 6);
      if ($urandom_range(0, 15) == 0 && kind_of(a) < 2)
        abort_txn(a, $urandom_range(1, TO - 1));
      else
        run_txn(a, 1'($urandom), $urandom, 4'($urandom), w, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_slave_router.md
Name: wb_slave_router

Overview:
Registered Wishbone routing controller between the management-SoC slave port and the two user slaves: UART at 0x30xx_xxxx and user memory at 0x38xx_xxxx. It accepts one transaction at a time and forwards it to the selected slave with latched address, data, select and write-enable. It returns a registered ack and data, and guarantees termination with a per-transaction timeout and an error response for unmapped addresses. It replaces the combinational stb/ack/data steering in the user wrapper.

Parameters:
UART_BASE  8'h30  wbs_adr_i[31:24] value selecting UART
MEM_BASE  8'h38  wbs_adr_i[31:24] value selecting memory
CSR_BASE  8'h3F  wbs_adr_i[31:24] value selecting router CSRs (used only with the optional feature)
TIMEOUT  255  max cycles waiting for a slave ack; legal range 2..255 (8-bit counter)
ERR_DATA  32'hBAD0_BAD0  read data returned on timeout or unmapped access

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset; synchronous, active-high
wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  upstream Wishbone controls
wbs_sel_i  in  4  upstream byte select
wbs_adr_i, wbs_dat_i  in  32 each  upstream address / write data
wbs_ack_o  out  1  registered ack
wbs_dat_o  out  32  registered read data
s_we_o  out  1  latched write-enable, shared by both slaves
s_sel_o  out  4  latched byte select, shared
s_adr_o, s_dat_o  out  32 each  latched address / write data, shared
uart_cyc_o, uart_stb_o  out  1 each  UART strobe pair
uart_ack_i  in  1  UART ack
uart_dat_i  in  32  UART read data
mem_cyc_o, mem_stb_o  out  1 each  memory strobe pair
mem_ack_i  in  1  memory ack
mem_dat_i  in  32  memory read data
err_irq_o  out  1  level; OR of sticky error flags

Behaviour:
- Reset: state=IDLE. All outputs 0, including the sticky flags to_flag and unmap_flag.
- States: IDLE, FWD, RESP.
- IDLE, accept condition: stb&cyc.
  - On accept, latch we/sel/adr/dat into s_* and decode adr[31:24].
  - UART or MEM hit → FWD. The target's cyc/stb go to 1 from the next cycle. Timeout counter clears to 0.
  - Unmapped → RESP with data ERR_DATA; set unmap_flag.
- FWD:
  - Target cyc/stb stay high. Counter increments each cycle.
  - Target ack=1: latch target dat (writes latch it too, don't-care), drop target cyc/stb next cycle, go to RESP.
  - Ack arriving on the non-selected slave is ignored.
  - Counter==TIMEOUT-1 with no ack: drop target, data=ERR_DATA, set to_flag, go to RESP.
  - Ack and timeout in the same cycle: ack wins.
  - wbs_cyc_i=0 (abort): drop target next cycle, go to IDLE, no upstream ack, flags unchanged.
- RESP:
  - wbs_ack_o=1 for exactly one cycle with the latched data, then IDLE.
  - wbs_dat_o returns to 0 when not acking.
  - Upstream stb/cyc are ignored in RESP.
- Latency:
  - Accept at cycle N, target stb from N+1.
  - Slave ack seen at M gives wbs_ack_o at M+1.
  - Zero-wait slave (ack in the first stb cycle) gives upstream ack at N+2.
- Only one transaction is outstanding. The next accept is possible in the cycle after RESP.
- Reset asserted mid-FWD: target stb drops on the next edge. No ack is emitted, and flags clear.
- err_irq_o = to_flag | unmap_flag. Without the optional feature, flags clear only on reset.

Optional Feature:
WB_ROUTER_STATS_EN
- Defined:
  - Address CSR_BASE decodes to internal registers and completes IDLE→RESP with no FWD.
  - Offset 0x0: RO 32-bit count of completed UART transactions.
  - Offset 0x4: RO 32-bit count of completed memory transactions.
  - Offset 0x8: bit0=to_flag, bit1=unmap_flag; write-1-to-clear using sel[0].
  - Other CSR offsets read 0.
  - Counters increment on ack-completed (not timed-out) transactions, wrap at 2^32, and clear on reset.
- Undefined: CSR_BASE is treated as unmapped (returns ERR_DATA and sets unmap_flag).

Test Plan:
- Read 0x3000_0004, UART acks 3 cycles after stb with 32'h0000_00A5 → uart_stb_o high 3 cycles, wbs_ack_o pulses once with 32'h0000_00A5, mem_stb_o stays 0.
- Write 0x3800_0010 data 32'h1234_5678 sel 4'hF, zero-wait memory → s_adr_o/s_dat_o latched, mem_stb_o 1 cycle, wbs_ack_o at accept+2.
- Read 0x3800_0000, memory never acks, TIMEOUT=16 → mem_stb_o drops after 16 cycles, wbs_ack_o with 32'hBAD0_BAD0, err_irq_o=1.
- Read 0x2000_0000 → no slave strobe, ack at accept+1 with ERR_DATA, err_irq_o=1.
- Abort (cyc low) during FWD, then wb_rst_i mid-FWD of a new transaction → no upstream ack, target stb drops next cycle, all outputs 0 after reset.
- STATS_EN: 2 UART + 1 memory completions, then read 0x3F00_0000 / 0x3F00_0004 → 2 / 1. Write 0x3 to 0x3F00_0008 → err_irq_o=0.
